load_store_unit: RTL and testbench

//  Memory stage directly downstream of the execute ALU. Takes the ALU result as the effective address.

---
 rtl/load_store_unit_pkg.sv | 37 +++
 rtl/lsu_align.sv | 47 ++++
 rtl/load_store_unit.sv | 201 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: funct3 width codes, fault codes, FSM states
// and the request-classification helpers used at issue time.
package load_store_unit_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  localparam logic [1:0] LSU_FAULT_NONE     = 2'b00;
  localparam logic [1:0] LSU_FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] LSU_FAULT_ILLEGAL  = 2'b10;
  localparam logic [1:0] LSU_FAULT_TIMEOUT  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Unsigned widths have no meaning for stores.
  function automatic logic funct3_legal(input logic [2:0] funct3, input logic is_store);
    case (funct3)
      LSU_B, LSU_H, LSU_W: return 1'b1;
      LSU_BU, LSU_HU:      return !is_store;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      LSU_H, LSU_HU: return offset[0];
      LSU_W:         return offset != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store data replication and byte strobes, plus load lane
// extraction with sign/zero extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  store_funct3,
  input  logic [1:0]  store_offset,
  input  logic [31:0] store_data,
  input  logic [2:0]  load_funct3,
  input  logic [1:0]  load_offset,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    wdata = store_data;
    wstrb = 4'b1111;
    case (store_funct3)
      LSU_B: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << store_offset;
      end
      LSU_H: begin
        wdata = {2{store_data[15:0]}};
        wstrb = 4'b0011 << store_offset;
      end
      default: ;
    endcase
  end

  assign shifted = rdata >> {load_offset, 3'b000};

  always_comb begin
    case (load_funct3)
      LSU_B:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      LSU_H:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      LSU_BU:  load_data = {24'd0, shifted[7:0]};
      LSU_HU:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: issues one RV32I load/store over a ready/valid port, stalls the pipeline
// while the access is in flight and returns extended load data with a fault code.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_input_valid,
  input  logic        lsu_input_is_load,
  input  logic        lsu_input_is_store,
  input  logic [2:0]  lsu_input_funct3,
  input  logic [31:0] lsu_input_addr,
  input  logic [31:0] lsu_input_store_data,
  input  logic [4:0]  lsu_input_rd,
  output logic        mem_output_req,
  output logic        mem_output_we,
  output logic [31:0] mem_output_addr,
  output logic [31:0] mem_output_wdata,
  output logic [3:0]  mem_output_wstrb,
  input  logic        mem_input_ready,
  input  logic        mem_input_rvalid,
  input  logic [31:0] mem_input_rdata,
  output logic        lsu_output_busy,
  output logic        lsu_output_valid,
  output logic [31:0] lsu_output_load_data,
  output logic [4:0]  lsu_output_rd,
  output logic [1:0]  lsu_output_fault
);

  logic [1:0]  state_q, state_d;
  logic        is_load_q, is_load_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  offset_q, offset_d;
  logic [4:0]  req_rd_q, req_rd_d;
  logic [31:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [31:0] load_data_q, load_data_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  fault_q, fault_d;

  logic        in_cmd, in_store;
  logic [31:0] cnt_inc;
  logic        timeout_hit;
  logic [31:0] align_wdata, align_load_data;
  logic [3:0]  align_wstrb;

  lsu_align u_align (
    .store_funct3 (lsu_input_funct3),
    .store_offset (lsu_input_addr[1:0]),
    .store_data   (lsu_input_store_data),
    .load_funct3  (funct3_q),
    .load_offset  (offset_q),
    .rdata        (mem_input_rdata),
    .wdata        (align_wdata),
    .wstrb        (align_wstrb),
    .load_data    (align_load_data)
  );

  assign in_cmd      = lsu_input_valid & (lsu_input_is_load | lsu_input_is_store);
  // A request flagged as both load and store is handled as a load.
  assign in_store    = lsu_input_is_store & ~lsu_input_is_load;
  assign cnt_inc     = cnt_q + 32'd1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc >= TIMEOUT_CYCLES);

  always_comb begin
    state_d     = state_q;
    is_load_d   = is_load_q;
    funct3_d    = funct3_q;
    offset_d    = offset_q;
    req_rd_d    = req_rd_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    valid_d     = 1'b0;
    load_data_d = load_data_q;
    rd_d        = rd_q;
    fault_d     = LSU_FAULT_NONE;

    case (state_q)
      ST_IDLE: begin
        if (in_cmd) begin
          if (!funct3_legal(lsu_input_funct3, in_store)) begin
            valid_d = 1'b1;
            fault_d = LSU_FAULT_ILLEGAL;
            rd_d    = 5'd0;
          end else if (is_misaligned(lsu_input_funct3, lsu_input_addr[1:0])) begin
            valid_d = 1'b1;
            fault_d = LSU_FAULT_MISALIGN;
            rd_d    = 5'd0;
          end else begin
            state_d   = ST_REQ;
            cnt_d     = 32'd0;
            is_load_d = ~in_store;
            funct3_d  = lsu_input_funct3;
            offset_d  = lsu_input_addr[1:0];
            req_rd_d  = lsu_input_rd;
            req_d     = 1'b1;
            we_d      = in_store;
            addr_d    = {lsu_input_addr[31:2], 2'b00};
            wdata_d   = in_store ? align_wdata : 32'd0;
            wstrb_d   = in_store ? align_wstrb : 4'b0000;
          end
        end
      end
      ST_REQ, ST_WAIT: begin
        // Completion takes priority over a timeout landing in the same cycle.
        if ((state_q == ST_REQ && mem_input_ready && (!is_load_q || mem_input_rvalid)) ||
            (state_q == ST_WAIT && mem_input_rvalid)) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          valid_d = 1'b1;
          if (is_load_q) begin
            load_data_d = align_load_data;
            rd_d        = req_rd_q;
          end else begin
            rd_d = 5'd0;
          end
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          valid_d = 1'b1;
          fault_d = LSU_FAULT_TIMEOUT;
          rd_d    = 5'd0;
        end else begin
          cnt_d = cnt_inc;
          if (state_q == ST_REQ && mem_input_ready) begin
            state_d = ST_WAIT;
            req_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      is_load_q   <= 1'b0;
      funct3_q    <= 3'd0;
      offset_q    <= 2'd0;
      req_rd_q    <= 5'd0;
      cnt_q       <= 32'd0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      load_data_q <= 32'd0;
      rd_q        <= 5'd0;
      fault_q     <= LSU_FAULT_NONE;
    end else begin
      state_q     <= state_d;
      is_load_q   <= is_load_d;
      funct3_q    <= funct3_d;
      offset_q    <= offset_d;
      req_rd_q    <= req_rd_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      load_data_q <= load_data_d;
      rd_q        <= rd_d;
      fault_q     <= fault_d;
    end
  end

  assign mem_output_req       = req_q;
  assign mem_output_we        = we_q;
  assign mem_output_addr      = addr_q;
  assign mem_output_wdata     = wdata_q;
  assign mem_output_wstrb     = wstrb_q;
  assign lsu_output_busy      = busy_q;
  assign lsu_output_valid     = valid_q;
  assign lsu_output_load_data = load_data_q;
  assign lsu_output_rd        = rd_q;
  assign lsu_output_fault     = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized requests
// against a transaction-level model of widths, faults, latency and timeouts.
module tb_load_store_unit;

  localparam int unsigned TMO = 4;

  logic        clk, reset;
  logic        lsu_input_valid, lsu_input_is_load, lsu_input_is_store;
  logic [2:0]  lsu_input_funct3;
  logic [31:0] lsu_input_addr, lsu_input_store_data;
  logic [4:0]  lsu_input_rd;
  logic        mem_output_req, mem_output_we;
  logic [31:0] mem_output_addr, mem_output_wdata;
  logic [3:0]  mem_output_wstrb;
  logic        mem_input_ready, mem_input_rvalid;
  logic [31:0] mem_input_rdata;
  logic        lsu_output_busy, lsu_output_valid;
  logic [31:0] lsu_output_load_data;
  logic [4:0]  lsu_output_rd;
  logic [1:0]  lsu_output_fault;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] last_ld = 32'd0;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk                  (clk),
    .reset                (reset),
    .lsu_input_valid      (lsu_input_valid),
    .lsu_input_is_load    (lsu_input_is_load),
    .lsu_input_is_store   (lsu_input_is_store),
    .lsu_input_funct3     (lsu_input_funct3),
    .lsu_input_addr       (lsu_input_addr),
    .lsu_input_store_data (lsu_input_store_data),
    .lsu_input_rd         (lsu_input_rd),
    .mem_output_req       (mem_output_req),
    .mem_output_we        (mem_output_we),
    .mem_output_addr      (mem_output_addr),
    .mem_output_wdata     (mem_output_wdata),
    .mem_output_wstrb     (mem_output_wstrb),
    .mem_input_ready      (mem_input_ready),
    .mem_input_rvalid     (mem_input_rvalid),
    .mem_input_rdata      (mem_input_rdata),
    .lsu_output_busy      (lsu_output_busy),
    .lsu_output_valid     (lsu_output_valid),
    .lsu_output_load_data (lsu_output_load_data),
    .lsu_output_rd        (lsu_output_rd),
    .lsu_output_fault     (lsu_output_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [1:0] ref_issue_fault(input logic ld, input logic st,
                                                 input logic [2:0] f3, input logic [31:0] a);
    logic store_only;
    int size;
    store_only = st && !ld;
    if (!(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || (!store_only && (f3 == 3'd4 || f3 == 3'd5))))
      return 2'b10;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if ((a % size) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata >> (8 * (a % 4));
    case (f3)
      3'd0: return v[7] ? (v | 32'hFFFF_FF00) : (v & 32'h0000_00FF);
      3'd1: return v[15] ? (v | 32'hFFFF_0000) : (v & 32'h0000_FFFF);
      3'd4: return v & 32'h0000_00FF;
      3'd5: return v & 32'h0000_FFFF;
      default: return v;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return d[7:0] * 32'h0101_0101;
    if (f3 == 3'd1) return d[15:0] * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [3:0] ref_wstrb(input logic [2:0] f3, input logic [31:0] a);
    int s;
    if (f3 == 3'd0) s = 1 << (a % 4);
    else if (f3 == 3'd1) s = 3 << (a % 4);
    else s = 15;
    return s[3:0];
  endfunction

  // Drive one request and act as memory: ready pulses in REQ cycle rdel, rvalid arrives vdel
  // cycles after that. Reports what the DUT did; comparisons are made by the callers.
  task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                       input int rdel, input int vdel, input logic [31:0] rdata,
                       output int lat, output logic [1:0] flt, output logic [4:0] ord,
                       output logic [31:0] ldata, output logic oreq, output logic owe,
                       output logic [31:0] oaddr, output logic [31:0] owdata,
                       output logic [3:0] owstrb, output logic stable, output logic busy_ok);
    int cyc;
    logic seen;
    lsu_input_valid = 1'b1;
    lsu_input_is_load = ld;
    lsu_input_is_store = st;
    lsu_input_funct3 = f3;
    lsu_input_addr = a;
    lsu_input_store_data = sd;
    lsu_input_rd = rd;
    @(negedge clk);
    lsu_input_valid = 1'b0;
    lsu_input_is_load = 1'b0;
    lsu_input_is_store = 1'b0;
    lsu_input_addr = $urandom;
    lsu_input_store_data = $urandom;
    oreq = mem_output_req;
    owe = mem_output_we;
    oaddr = mem_output_addr;
    owdata = mem_output_wdata;
    owstrb = mem_output_wstrb;
    cyc = 1; seen = 1'b0; stable = 1'b1; busy_ok = 1'b1;
    lat = 0; flt = 2'b00; ord = 5'd0; ldata = 32'd0;
    while (!seen && cyc <= 40) begin
      if (lsu_output_valid) begin
        seen = 1'b1;
        lat = cyc;
        flt = lsu_output_fault;
        ord = lsu_output_rd;
        ldata = lsu_output_load_data;
        if (lsu_output_busy || mem_output_req) busy_ok = 1'b0;
      end else begin
        if (!lsu_output_busy) busy_ok = 1'b0;
        if (cyc - 1 <= rdel) begin
          if (!mem_output_req || mem_output_we !== owe || mem_output_addr !== oaddr ||
              mem_output_wdata !== owdata || mem_output_wstrb !== owstrb) stable = 1'b0;
        end else if (mem_output_req) begin
          stable = 1'b0;
        end
        mem_input_ready = (cyc - 1 == rdel);
        mem_input_rvalid = ld && (cyc - 1 == rdel + vdel);
        mem_input_rdata = mem_input_rvalid ? rdata : $urandom;
        @(negedge clk);
        mem_input_ready = 1'b0;
        mem_input_rvalid = 1'b0;
        cyc++;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({mem_output_req, mem_output_we, mem_output_addr, mem_output_wdata, mem_output_wstrb,
         lsu_output_busy, lsu_output_valid, lsu_output_load_data, lsu_output_rd,
         lsu_output_fault} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h wstrb=%b busy=%b valid=%b ld=%h rd=%0d fault=%b, required all 0",
               mem_output_req, mem_output_we, mem_output_addr, mem_output_wdata, mem_output_wstrb,
               lsu_output_busy, lsu_output_valid, lsu_output_load_data, lsu_output_rd,
               lsu_output_fault);
    end
    reset = 1'b0;
    last_ld = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_store_byte();
    int lat; logic [1:0] f; logic [4:0] r; logic [31:0] ld, oa, ow; logic q, we, stb, bok;
    logic [3:0] os;
    do_op(1'b0, 1'b1, 3'd0, 32'h1003, 32'h0000_00AB, 5'd9, 0, 0, 32'd0,
          lat, f, r, ld, q, we, oa, ow, os, stb, bok);
    n_vec++;
    if (ow !== 32'hABAB_ABAB || os !== 4'b1000 || oa !== 32'h1000 || !q || !we) begin
      n_err++;
      $display("FAIL sb_lanes: req=%b we=%b addr=%h wdata=%h wstrb=%b, required 1 1 00001000 abababab 1000",
               q, we, oa, ow, os);
    end
    n_vec++;
    if (lat != 2 || f !== 2'b00 || r !== 5'd0 || ld !== last_ld) begin
      n_err++;
      $display("FAIL sb_complete: lat=%0d fault=%b rd=%0d ld=%h, required 2 00 0 %h",
               lat, f, r, ld, last_ld);
    end
  endtask

  task automatic test_load_byte();
    int lat; logic [1:0] f; logic [4:0] r; logic [31:0] ld, oa, ow; logic q, we, stb, bok;
    logic [3:0] os;
    do_op(1'b1, 1'b0, 3'd0, 32'h2002, 32'd0, 5'd7, 0, 1, 32'h0080_0000,
          lat, f, r, ld, q, we, oa, ow, os, stb, bok);
    n_vec++;
    if (lat != 3 || f !== 2'b00 || r !== 5'd7 || ld !== 32'hFFFF_FF80 || oa !== 32'h2000 ||
        os !== 4'd0 || we) begin
      n_err++;
      $display("FAIL lb_sext: lat=%0d fault=%b rd=%0d ld=%h addr=%h wstrb=%b we=%b, required 3 00 7 ffffff80 00002000 0000 0",
               lat, f, r, ld, oa, os, we);
    end
    do_op(1'b1, 1'b0, 3'd4, 32'h2002, 32'd0, 5'd12, 0, 1, 32'h0080_0000,
          lat, f, r, ld, q, we, oa, ow, os, stb, bok);
    n_vec++;
    if (lat != 3 || f !== 2'b00 || r !== 5'd12 || ld !== 32'h0000_0080) begin
      n_err++;
      $display("FAIL lbu_zext: lat=%0d fault=%b rd=%0d ld=%h, required 3 00 12 00000080",
               lat, f, r, ld);
    end
    last_ld = 32'h0000_0080;
  endtask

  task automatic test_faults();
    int lat; logic [1:0] f; logic [4:0] r; logic [31:0] ld, oa, ow; logic q, we, stb, bok;
    logic [3:0] os;
    do_op(1'b1, 1'b0, 3'd2, 32'h3002, 32'd0, 5'd3, 0, 0, 32'd0,
          lat, f, r, ld, q, we, oa, ow, os, stb, bok);
    n_vec++;
    if (lat != 1 || f !== 2'b01 || q || r !== 5'd0 || !bok) begin
      n_err++;
      $display("FAIL lw_misalign: lat=%0d fault=%b req=%b rd=%0d busy_ok=%b, required 1 01 0 0 1",
               lat, f, q, r, bok);
    end
    do_op(1'b1, 1'b0, 3'd3, 32'h3000, 32'd0, 5'd3, 0, 0, 32'd0,
          lat, f, r, ld, q, we, oa, ow, os, stb, bok);
    n_vec++;
    if (lat != 1 || f !== 2'b10 || q) begin
      n_err++;
      $display("FAIL f3_011: lat=%0d fault=%b req=%b, required 1 10 0", lat, f, q);
    end
    do_op(1'b0, 1'b1, 3'd4, 32'h3000, 32'd0, 5'd3, 0, 0, 32'd0,
          lat, f, r, ld, q, we, oa, ow, os, stb, bok);
    n_vec++;
    if (lat != 1 || f !== 2'b10 || q) begin
      n_err++;
      $display("FAIL store_unsigned: lat=%0d fault=%b req=%b, required 1 10 0", lat, f, q);
    end
    // Neither load nor store flagged: nothing happens.
    lsu_input_valid = 1'b1;
    lsu_input_funct3 = 3'd2;
    lsu_input_addr = 32'h3000;
    @(negedge clk);
    lsu_input_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (lsu_output_busy || lsu_output_valid || mem_output_req) begin
      n_err++;
      $display("FAIL no_flags: busy=%b valid=%b req=%b, required 0 0 0",
               lsu_output_busy, lsu_output_valid, mem_output_req);
    end
  endtask

  task automatic test_ready_stall();
    int lat; logic [1:0] f; logic [4:0] r; logic [31:0] ld, oa, ow; logic q, we, stb, bok;
    logic [3:0] os;
    // Ready in the 4th REQ cycle together with rvalid: last cycle before the timeout.
    do_op(1'b1, 1'b0, 3'd1, 32'h4002, 32'd0, 5'd20, 3, 0, 32'h8001_1234,
          lat, f, r, ld, q, we, oa, ow, os, stb, bok);
    n_vec++;
    if (lat != 5 || f !== 2'b00 || r !== 5'd20 || ld !== 32'hFFFF_8001 || !stb || !bok) begin
      n_err++;
      $display("FAIL lh_stall: lat=%0d fault=%b rd=%0d ld=%h stable=%b busy_ok=%b, required 5 00 20 ffff8001 1 1",
               lat, f, r, ld, stb, bok);
    end
    do_op(1'b1, 1'b0, 3'd5, 32'h4000, 32'd0, 5'd21, 0, 0, 32'h0000_F00D,
          lat, f, r, ld, q, we, oa, ow, os, stb, bok);
    n_vec++;
    if (lat != 2 || f !== 2'b00 || r !== 5'd21 || ld !== 32'h0000_F00D) begin
      n_err++;
      $display("FAIL lhu_same_cycle: lat=%0d fault=%b rd=%0d ld=%h, required 2 00 21 0000f00d",
               lat, f, r, ld);
    end
    last_ld = 32'h0000_F00D;
  endtask

  task automatic test_timeout();
    int lat; logic [1:0] f; logic [4:0] r; logic [31:0] ld, oa, ow; logic q, we, stb, bok;
    logic [3:0] os;
    do_op(1'b0, 1'b1, 3'd2, 32'h5000, 32'h1234_5678, 5'd5, 100, 0, 32'd0,
          lat, f, r, ld, q, we, oa, ow, os, stb, bok);
    n_vec++;
    if (lat != int'(TMO) + 1 || f !== 2'b11 || r !== 5'd0 || !stb || !bok) begin
      n_err++;
      $display("FAIL timeout: lat=%0d fault=%b rd=%0d stable=%b busy_ok=%b, required %0d 11 0 1 1",
               lat, f, r, stb, bok, TMO + 1);
    end
    mem_input_rvalid = 1'b1;
    mem_input_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_input_rvalid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (lsu_output_valid || lsu_output_busy || lsu_output_load_data !== last_ld) begin
      n_err++;
      $display("FAIL stray_rvalid: valid=%b busy=%b ld=%h, required 0 0 %h",
               lsu_output_valid, lsu_output_busy, lsu_output_load_data, last_ld);
    end
  endtask

  task automatic test_reset_mid_access();
    int lat; logic [1:0] f; logic [4:0] r; logic [31:0] ld, oa, ow; logic q, we, stb, bok;
    logic [3:0] os;
    logic [31:0] rdv;
    lsu_input_valid = 1'b1; lsu_input_is_load = 1'b1; lsu_input_funct3 = 3'd2;
    lsu_input_addr = 32'h6000; lsu_input_rd = 5'd4;
    @(negedge clk);
    lsu_input_valid = 1'b0; lsu_input_is_load = 1'b0;
    mem_input_ready = 1'b1;
    @(negedge clk);
    mem_input_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if ({mem_output_req, mem_output_we, mem_output_addr, mem_output_wdata, mem_output_wstrb,
         lsu_output_busy, lsu_output_valid, lsu_output_load_data, lsu_output_rd,
         lsu_output_fault} !== '0) begin
      n_err++;
      $display("FAIL reset_in_wait: req=%b busy=%b valid=%b ld=%h rd=%0d fault=%b addr=%h, required all 0",
               mem_output_req, lsu_output_busy, lsu_output_valid, lsu_output_load_data,
               lsu_output_rd, lsu_output_fault, mem_output_addr);
    end
    last_ld = 32'd0;
    mem_input_rvalid = 1'b1;
    mem_input_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_input_rvalid = 1'b0;
    n_vec++;
    if (lsu_output_valid || lsu_output_load_data !== 32'd0) begin
      n_err++;
      $display("FAIL post_reset_rvalid: valid=%b ld=%h, required 0 00000000",
               lsu_output_valid, lsu_output_load_data);
    end
    rdv = $urandom;
    do_op(1'b1, 1'b0, 3'd2, 32'h7004, 32'd0, 5'd11, 0, 0, rdv,
          lat, f, r, ld, q, we, oa, ow, os, stb, bok);
    n_vec++;
    if (lat != 2 || f !== 2'b00 || r !== 5'd11 || ld !== rdv || oa !== 32'h7004) begin
      n_err++;
      $display("FAIL lw_after_reset: lat=%0d fault=%b rd=%0d ld=%h addr=%h, required 2 00 11 %h 00007004",
               lat, f, r, ld, oa, rdv);
    end
    last_ld = rdv;
  endtask

  // Back-to-back random requests; the next one is offered in the completion cycle.
  task automatic test_random(input int n);
    int lat, rdel, vdel, done, e_lat; logic [1:0] f, e_f; logic [4:0] r, e_rd, rd;
    logic [31:0] ld, oa, ow, a, sd, rdv, e_ld; logic q, we, stb, bok, l, s;
    logic [3:0] os; logic [2:0] f3;
    for (int i = 0; i < n; i++) begin
      l = $urandom_range(0, 1);
      s = l ? 1'($urandom_range(0, 1)) : 1'b1;
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = (l ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 2)));
      a = $urandom;
      sd = $urandom;
      rd = 5'($urandom);
      rdv = $urandom;
      rdel = $urandom_range(0, 4);
      vdel = $urandom_range(0, 3);
      do_op(l, s, f3, a, sd, rd, rdel, vdel, rdv, lat, f, r, ld, q, we, oa, ow, os, stb, bok);
      e_f = ref_issue_fault(l, s, f3, a);
      e_rd = 5'd0;
      e_ld = last_ld;
      if (e_f != 2'b00) begin
        e_lat = 1;
      end else begin
        done = l ? rdel + vdel : rdel;
        if (done > int'(TMO) - 1) begin
          e_lat = int'(TMO) + 1;
          e_f = 2'b11;
        end else begin
          e_lat = done + 2;
          if (l) begin
            e_rd = rd;
            e_ld = ref_load(f3, a, rdv);
          end
        end
        n_vec++;
        if (!q || we !== !l || oa !== {a[31:2], 2'b00} || os !== (l ? 4'd0 : ref_wstrb(f3, a)) ||
            (!l && ow !== ref_wdata(f3, sd)) || !stb || !bok) begin
          n_err++;
          $display("FAIL rand_req[%0d]: req=%b we=%b addr=%h wdata=%h wstrb=%b stable=%b busy_ok=%b, required 1 %b %h %h %b 1 1",
                   i, q, we, oa, ow, os, stb, bok, !l, {a[31:2], 2'b00}, ref_wdata(f3, sd),
                   l ? 4'd0 : ref_wstrb(f3, a));
        end
      end
      n_vec++;
      if (lat != e_lat || f !== e_f || r !== e_rd || ld !== e_ld || (e_lat == 1 && q)) begin
        n_err++;
        $display("FAIL rand_done[%0d] l=%b s=%b f3=%0d a=%h rdel=%0d vdel=%0d: lat=%0d fault=%b rd=%0d ld=%h req=%b, required %0d %b %0d %h",
                 i, l, s, f3, a, rdel, vdel, lat, f, r, ld, q, e_lat, e_f, e_rd, e_ld);
      end
      last_ld = e_ld;
    end
  endtask

  initial begin
    reset = 1'b1;
    lsu_input_valid = 1'b0; lsu_input_is_load = 1'b0; lsu_input_is_store = 1'b0;
    lsu_input_funct3 = 3'd0; lsu_input_addr = 32'd0; lsu_input_store_data = 32'd0;
    lsu_input_rd = 5'd0;
    mem_input_ready = 1'b0; mem_input_rvalid = 1'b0; mem_input_rdata = 32'd0;
    @(negedge clk);
    test_reset();
    test_store_byte();
    test_load_byte();
    test_faults();
    test_ready_stall();
    test_timeout();
    test_reset_mid_access();
    test_random(200);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
